// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit: FSM encoding,
// control_mem bit positions and parameter defaults.
package mem_access_unit_pkg;

  localparam int DATA_W_DEF         = 32;
  localparam int ZERO_BIT_DEF       = 0;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam int CM_BRANCH = 2;
  localparam int CM_READ   = 1;
  localparam int CM_WRITE  = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Word accesses only: any set low address bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit (master) and
// a variable-latency data memory (slave).
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Watchdog for a pending data-memory access: flags a timeout on the
// TIMEOUT_CYCLES-th consecutive BUSY cycle without dmem_ready.
module mem_timeout_counter
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ready,
  output logic timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside BUSY, so every access starts from a cleared count.
  always_comb begin
    cnt_d = busy ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = busy & ~ready & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: branch resolution, load/store handshake with a
// variable-latency data memory, upstream stall and MEM/WB registers.
// Optional watchdog and bus_error port: define MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_BIT = ZERO_BIT_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [2:0]         control_mem_in,
  input  logic [1:0]         control_wb_in,
  input  logic [DATA_W-1:0]  branch_address_in,
  input  logic [7:0]         ALU_status_in,
  input  logic [DATA_W-1:0]  ALU_result_in,
  input  logic [DATA_W-1:0]  read_data_2_in,
  input  logic [DATA_W-1:0]  reg_dst_address_in,
  mem_access_unit_if.master  dmem,
  output logic               stall,
  output logic               pc_src,
  output logic [DATA_W-1:0]  branch_target,
  output logic               access_fault,
  output logic [DATA_W-1:0]  mem_read_data_out,
  output logic [DATA_W-1:0]  ALU_result_out,
  output logic [1:0]         control_wb_out,
  output logic [DATA_W-1:0]  reg_dst_address_out,
  output logic               wb_valid
`ifdef MEM_TIMEOUT_EN
  , output logic             bus_error
`endif
);
  state_e state_q, state_d;

  logic [DATA_W-1:0] lat_addr_q, lat_addr_d, lat_wdata_q, lat_wdata_d, lat_dst_q, lat_dst_d;
  logic [1:0]        lat_wb_q, lat_wb_d;
  logic              lat_we_q, lat_we_d;
  logic [DATA_W-1:0] mem_read_data_q, mem_read_data_d, alu_result_q, alu_result_d;
  logic [DATA_W-1:0] reg_dst_q, reg_dst_d;
  logic [1:0]        control_wb_q, control_wb_d;
  logic              wb_valid_q, wb_valid_d;

  logic mem_read, mem_write, access, fault, is_busy, timeout, done;
  logic status_unused;

  assign mem_read  = control_mem_in[CM_READ];
  assign mem_write = control_mem_in[CM_WRITE];
  assign access    = mem_read | mem_write;
  assign fault     = access & (is_misaligned(ALU_result_in[1:0]) | (mem_read & mem_write));
  assign is_busy   = (state_q == S_BUSY);

  // Only the zero flag takes part in branch resolution.
  assign status_unused = ^ALU_status_in;
  assign pc_src        = control_mem_in[CM_BRANCH] & ALU_status_in[ZERO_BIT];
  assign branch_target = branch_address_in;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (CLK),
    .rst_n   (RST_N),
    .busy    (is_busy),
    .ready   (dmem.dmem_ready),
    .timeout (timeout)
  );
  assign bus_error = timeout;
`else
  assign timeout = 1'b0;
`endif

  assign done = is_busy & (dmem.dmem_ready | timeout);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (access && !fault) state_d = S_BUSY;
      S_BUSY: if (done)             state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    stall           = 1'b0;
    access_fault    = 1'b0;
    lat_addr_d      = lat_addr_q;
    lat_wdata_d     = lat_wdata_q;
    lat_we_d        = lat_we_q;
    lat_wb_d        = lat_wb_q;
    lat_dst_d       = lat_dst_q;
    mem_read_data_d = mem_read_data_q;
    alu_result_d    = alu_result_q;
    reg_dst_d       = reg_dst_q;
    control_wb_d    = control_wb_q;
    wb_valid_d      = wb_valid_q;
    case (state_q)
      S_IDLE: begin
        if (access && !fault) begin
          stall        = 1'b1;
          lat_addr_d   = ALU_result_in;
          lat_wdata_d  = read_data_2_in;
          lat_we_d     = mem_write;
          lat_wb_d     = control_wb_in;
          lat_dst_d    = reg_dst_address_in;
          control_wb_d = 2'b00;
          wb_valid_d   = 1'b0;
        end else begin
          // A faulting access still retires, but with write-back disabled.
          access_fault = fault;
          alu_result_d = ALU_result_in;
          reg_dst_d    = reg_dst_address_in;
          control_wb_d = fault ? 2'b00 : control_wb_in;
          wb_valid_d   = 1'b1;
        end
      end
      S_BUSY: begin
        stall = ~done;
        if (done) begin
          if (!lat_we_q && !timeout) mem_read_data_d = dmem.dmem_rdata;
          alu_result_d = lat_addr_q;
          reg_dst_d    = lat_dst_q;
          control_wb_d = timeout ? 2'b00 : lat_wb_q;
          wb_valid_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_addr_q      <= '0;
      lat_wdata_q     <= '0;
      lat_we_q        <= 1'b0;
      lat_wb_q        <= '0;
      lat_dst_q       <= '0;
      mem_read_data_q <= '0;
      alu_result_q    <= '0;
      reg_dst_q       <= '0;
      control_wb_q    <= '0;
      wb_valid_q      <= 1'b0;
    end else begin
      lat_addr_q      <= lat_addr_d;
      lat_wdata_q     <= lat_wdata_d;
      lat_we_q        <= lat_we_d;
      lat_wb_q        <= lat_wb_d;
      lat_dst_q       <= lat_dst_d;
      mem_read_data_q <= mem_read_data_d;
      alu_result_q    <= alu_result_d;
      reg_dst_q       <= reg_dst_d;
      control_wb_q    <= control_wb_d;
      wb_valid_q      <= wb_valid_d;
    end
  end

  assign dmem.dmem_req    = is_busy;
  assign dmem.dmem_we     = lat_we_q;
  assign dmem.dmem_addr   = lat_addr_q;
  assign dmem.dmem_wdata  = lat_wdata_q;

  assign mem_read_data_out   = mem_read_data_q;
  assign ALU_result_out      = alu_result_q;
  assign control_wb_out      = control_wb_q;
  assign reg_dst_address_out = reg_dst_q;
  assign wb_valid            = wb_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; define MEM_TIMEOUT_EN to
// also build the watchdog scenario with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [2:0]   control_mem_in;
  logic [1:0]   control_wb_in;
  logic [W-1:0] branch_address_in, ALU_result_in, read_data_2_in, reg_dst_address_in;
  logic [7:0]   ALU_status_in;
  logic         stall, pc_src, access_fault, wb_valid;
  logic [W-1:0] branch_target, mem_read_data_out, ALU_result_out, reg_dst_address_out;
  logic [1:0]   control_wb_out;
`ifdef MEM_TIMEOUT_EN
  logic         bus_error;
`endif

  int total = 0;
  int bad   = 0;

  mem_access_unit_if #(.DATA_W(W)) dmem_if ();

  mem_access_unit #(
    .DATA_W(W), .ZERO_BIT(0)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .control_mem_in(control_mem_in), .control_wb_in(control_wb_in),
    .branch_address_in(branch_address_in), .ALU_status_in(ALU_status_in),
    .ALU_result_in(ALU_result_in), .read_data_2_in(read_data_2_in),
    .reg_dst_address_in(reg_dst_address_in),
    .dmem(dmem_if.master),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .access_fault(access_fault), .mem_read_data_out(mem_read_data_out),
    .ALU_result_out(ALU_result_out), .control_wb_out(control_wb_out),
    .reg_dst_address_out(reg_dst_address_out), .wb_valid(wb_valid)
`ifdef MEM_TIMEOUT_EN
    , .bus_error(bus_error)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    control_mem_in = '0; control_wb_in = '0; branch_address_in = '0; ALU_status_in = '0;
    ALU_result_in = '0; read_data_2_in = '0; reg_dst_address_in = '0;
    dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rdata = '0;
  endtask

  task automatic access_in(input logic [2:0] cm, input logic [W-1:0] addr, input logic [W-1:0] wd,
                           input logic [1:0] wb, input logic [W-1:0] dst);
    control_mem_in = cm; ALU_result_in = addr; read_data_2_in = wd;
    control_wb_in = wb; reg_dst_address_in = dst;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    idle_in();
    #3;
    total++;
    if ({dmem_if.dmem_req, stall, pc_src, access_fault, wb_valid, control_wb_out} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {dmem_if.dmem_req, stall, pc_src, access_fault, wb_valid, control_wb_out});
    end
    total++;
    if ({mem_read_data_out, ALU_result_out, reg_dst_address_out} !== {3*W{1'b0}}) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {mem_read_data_out, ALU_result_out, reg_dst_address_out});
    end
    #4 RST_N = 1'b1;
    tick();
  endtask

  task automatic test_load;
    int n_stall;
    access_in(3'b010, 32'h100, 32'h0, 2'b11, 32'd5);
    #1 n_stall = int'(stall);
    tick(); #1;
    n_stall += int'(stall);
    total++;
    if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL load_bus got=%h exp=%h", {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr}, {1'b1, 1'b0, 32'h100});
    end
    total++;
    if ({wb_valid, control_wb_out} !== 3'b000) begin
      bad++; $display("FAIL load_bubble got=%b exp=000", {wb_valid, control_wb_out});
    end
    repeat (2) begin tick(); #1; n_stall += int'(stall); end
    tick();
    dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL load_ready_stall got=%b exp=0", stall); end
    tick();
    total++;
    if (mem_read_data_out !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_data got=%h exp=deadbeef", mem_read_data_out);
    end
    total++;
    if ({wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out} !== {1'b1, 2'b11, 32'h100, 32'd5}) begin
      bad++; $display("FAIL load_wb got=%h exp=%h", {wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out}, {1'b1, 2'b11, 32'h100, 32'd5});
    end
    idle_in();
    #1;
    total++;
    if (dmem_if.dmem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", dmem_if.dmem_req); end
    total++;
    if (n_stall != 4) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=4", n_stall); end
  endtask

  task automatic test_store;
    access_in(3'b001, 32'h204, 32'h12345678, 2'b10, 32'd7);
    dmem_if.dmem_ready = 1'b1;  // ignored while IDLE
    #1;
    total++;
    if ({stall, dmem_if.dmem_req} !== 2'b10) begin bad++; $display("FAIL store_issue got=%b exp=10", {stall, dmem_if.dmem_req}); end
    tick(); #1;
    total++;
    if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata, stall} !== {2'b11, 32'h204, 32'h12345678, 1'b0}) begin
      bad++; $display("FAIL store_bus got=%h exp=%h", {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata, stall}, {2'b11, 32'h204, 32'h12345678, 1'b0});
    end
    tick();
    total++;
    if ({mem_read_data_out, wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out} !== {32'hDEADBEEF, 1'b1, 2'b10, 32'h204, 32'd7}) begin
      bad++; $display("FAIL store_wb got=%h exp=%h", {mem_read_data_out, wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out}, {32'hDEADBEEF, 1'b1, 2'b10, 32'h204, 32'd7});
    end
    idle_in();
  endtask

  task automatic test_misaligned;
    access_in(3'b010, 32'h102, 32'h0, 2'b11, 32'd9);
    #1;
    total++;
    if ({access_fault, stall, dmem_if.dmem_req} !== 3'b100) begin
      bad++; $display("FAIL misaligned_fault got=%b exp=100", {access_fault, stall, dmem_if.dmem_req});
    end
    tick();
    total++;
    if ({control_wb_out, wb_valid, ALU_result_out, reg_dst_address_out, dmem_if.dmem_req} !== {2'b00, 1'b1, 32'h102, 32'd9, 1'b0}) begin
      bad++; $display("FAIL misaligned_wb got=%h exp=%h", {control_wb_out, wb_valid, ALU_result_out, reg_dst_address_out, dmem_if.dmem_req}, {2'b00, 1'b1, 32'h102, 32'd9, 1'b0});
    end
    idle_in();
    #1;
    total++;
    if (access_fault !== 1'b0) begin bad++; $display("FAIL misaligned_pulse got=%b exp=0", access_fault); end
    access_in(3'b011, 32'h200, 32'h0, 2'b01, 32'd2);
    #1;
    total++;
    if ({access_fault, stall} !== 2'b10) begin bad++; $display("FAIL rw_fault got=%b exp=10", {access_fault, stall}); end
    tick();
    total++;
    if ({dmem_if.dmem_req, control_wb_out} !== 3'b000) begin bad++; $display("FAIL rw_noreq got=%b exp=000", {dmem_if.dmem_req, control_wb_out}); end
    idle_in();
  endtask

  task automatic test_branch;
    access_in(3'b100, 32'h40, 32'h0, 2'b01, 32'd3);
    branch_address_in = 32'h40; ALU_status_in = 8'h01;
    #1;
    total++;
    if ({pc_src, branch_target, stall} !== {1'b1, 32'h40, 1'b0}) begin
      bad++; $display("FAIL branch_taken got=%h exp=%h", {pc_src, branch_target, stall}, {1'b1, 32'h40, 1'b0});
    end
    ALU_status_in = 8'hFE;
    #1;
    total++;
    if (pc_src !== 1'b0) begin bad++; $display("FAIL branch_not_zero got=%b exp=0", pc_src); end
    ALU_status_in = 8'h01; control_mem_in = 3'b000;
    #1;
    total++;
    if (pc_src !== 1'b0) begin bad++; $display("FAIL branch_no_bit got=%b exp=0", pc_src); end
    control_mem_in = 3'b100;
    tick();
    total++;
    if ({wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out, mem_read_data_out} !== {1'b1, 2'b01, 32'h40, 32'd3, 32'hDEADBEEF}) begin
      bad++; $display("FAIL passthrough got=%h exp=%h", {wb_valid, control_wb_out, ALU_result_out, reg_dst_address_out, mem_read_data_out}, {1'b1, 2'b01, 32'h40, 32'd3, 32'hDEADBEEF});
    end
    access_in(3'b110, 32'h300, 32'h0, 2'b11, 32'd6);
    #1;
    total++;
    if ({pc_src, stall} !== 2'b11) begin bad++; $display("FAIL branch_load got=%b exp=11", {pc_src, stall}); end
    tick();
    dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rdata = 32'hCAFEF00D;
    #1;
    total++;
    if ({pc_src, dmem_if.dmem_req, dmem_if.dmem_addr} !== {2'b11, 32'h300}) begin
      bad++; $display("FAIL branch_load_busy got=%h exp=%h", {pc_src, dmem_if.dmem_req, dmem_if.dmem_addr}, {2'b11, 32'h300});
    end
    tick();
    total++;
    if (mem_read_data_out !== 32'hCAFEF00D) begin bad++; $display("FAIL branch_load_data got=%h exp=cafef00d", mem_read_data_out); end
    idle_in();
  endtask

  task automatic test_back_to_back;
    access_in(3'b010, 32'h10, 32'h0, 2'b01, 32'd1);
    tick();
    dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rdata = 32'h11111111;
    tick();
    total++;
    if ({mem_read_data_out, reg_dst_address_out} !== {32'h11111111, 32'd1}) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h", {mem_read_data_out, reg_dst_address_out}, {32'h11111111, 32'd1});
    end
    access_in(3'b010, 32'h14, 32'h0, 2'b01, 32'd2);
    dmem_if.dmem_ready = 1'b0;
    #1;
    total++;
    if ({stall, dmem_if.dmem_req} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b exp=10", {stall, dmem_if.dmem_req}); end
    tick();
    dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rdata = 32'h22222222;
    #1;
    total++;
    if ({dmem_if.dmem_req, dmem_if.dmem_addr} !== {1'b1, 32'h14}) begin
      bad++; $display("FAIL b2b_bus got=%h exp=%h", {dmem_if.dmem_req, dmem_if.dmem_addr}, {1'b1, 32'h14});
    end
    tick();
    total++;
    if ({mem_read_data_out, reg_dst_address_out, wb_valid} !== {32'h22222222, 32'd2, 1'b1}) begin
      bad++; $display("FAIL b2b_second got=%h exp=%h", {mem_read_data_out, reg_dst_address_out, wb_valid}, {32'h22222222, 32'd2, 1'b1});
    end
    idle_in();
  endtask

  task automatic test_reset_mid_busy;
    access_in(3'b010, 32'h400, 32'h0, 2'b11, 32'd8);
    tick(); #1;
    total++;
    if (dmem_if.dmem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", dmem_if.dmem_req); end
    #1 RST_N = 1'b0;
    #1;
    total++;
    if ({dmem_if.dmem_req, wb_valid, control_wb_out, mem_read_data_out, ALU_result_out, reg_dst_address_out} !== {4'b0, {3*W{1'b0}}}) begin
      bad++; $display("FAIL rst_mid_busy got=%h exp=0", {dmem_if.dmem_req, wb_valid, control_wb_out, mem_read_data_out, ALU_result_out, reg_dst_address_out});
    end
    idle_in();
    #3 RST_N = 1'b1;
    tick();
    total++;
    if ({dmem_if.dmem_req, stall, wb_valid, control_wb_out} !== 5'b00100) begin
      bad++; $display("FAIL rst_release got=%b exp=00100", {dmem_if.dmem_req, stall, wb_valid, control_wb_out});
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    access_in(3'b010, 32'h500, 32'h0, 2'b11, 32'd4);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++;
      if ({bus_error, dmem_if.dmem_req, stall} !== 3'b011) begin
        bad++; $display("FAIL timeout_wait%0d got=%b exp=011", c, {bus_error, dmem_if.dmem_req, stall});
      end
      tick();
    end
    #1;
    total++;
    if ({bus_error, stall} !== 2'b10) begin bad++; $display("FAIL timeout_pulse got=%b exp=10", {bus_error, stall}); end
    tick();
    total++;
    if ({dmem_if.dmem_req, bus_error, control_wb_out, wb_valid} !== 5'b00001) begin
      bad++; $display("FAIL timeout_wb got=%b exp=00001", {dmem_if.dmem_req, bus_error, control_wb_out, wb_valid});
    end
    idle_in();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_branch();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branches from the EX/MEM branch bit and the ALU zero flag.
- Runs load/store handshakes with a variable-latency data memory and stalls upstream until each access finishes.
- Drives the MEM/WB boundary registers: load data, ALU result, write-back control, destination register.

Parameters:
DATA_W, 32, width of address/data/result buses
TIMEOUT_CYCLES, 16, BUSY cycles without dmem_ready before bus error (MEM_TIMEOUT_EN only)
ZERO_BIT, 0, index of the zero flag in ALU_status_in

Ports:
CLK  in  1  clock, all state on posedge
RST_N  in  1  asynchronous active-low reset
control_mem_in  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
control_wb_in  in  2  write-back control, passed to WB
branch_address_in  in  DATA_W  branch target
ALU_status_in  in  8  ALU flags
ALU_result_in  in  DATA_W  memory address / ALU result
read_data_2_in  in  DATA_W  store data
reg_dst_address_in  in  DATA_W  destination register index
dmem_req  out  1  memory request, held until dmem_ready
dmem_we  out  1  1=write, 0=read
dmem_addr  out  DATA_W  latched address
dmem_wdata  out  DATA_W  latched store data
dmem_ready  in  1  completion strobe, sampled only in BUSY
dmem_rdata  in  DATA_W  load data, valid with dmem_ready
stall  out  1  upstream (PC, IF/ID, ID/EX, EX/MEM) must hold
pc_src  out  1  branch taken
branch_target  out  DATA_W  equals branch_address_in
access_fault  out  1  one-cycle pulse for misaligned or read+write
mem_read_data_out  out  DATA_W  MEM/WB load data
ALU_result_out  out  DATA_W  MEM/WB ALU result
control_wb_out  out  2  MEM/WB write-back control
reg_dst_address_out  out  DATA_W  MEM/WB destination
wb_valid  out  1  MEM/WB holds a completed instruction

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; all registered outputs 0; dmem_req drops immediately. Mid-access reset abandons the access with no write-back.
- Combinational outputs: pc_src = control_mem_in[2] & ALU_status_in[ZERO_BIT]; branch_target = branch_address_in.
- access = mem_read|mem_write. fault = access & (ALU_result_in[1:0]!=0 | (mem_read & mem_write)).
- FSM states: IDLE, BUSY.
- IDLE, access & !fault:
  - latch address, store data, we=mem_write, wb control and destination into internal regs; next state BUSY.
  - stall=1 this cycle.
  - MEM/WB at this edge: wb_valid=0, control_wb_out=0 (bubble).
- IDLE, fault:
  - access_fault=1 this cycle; no request issued; stall=0.
  - MEM/WB at this edge: control_wb_out=0, wb_valid=1; ALU_result_out and reg_dst_address_out still loaded.
- IDLE, no access: MEM/WB at this edge loads ALU_result_in, control_wb_in, reg_dst_address_in; wb_valid=1; mem_read_data_out keeps its value.
- BUSY:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the latches and stay stable until dmem_ready.
  - stall=1 while dmem_ready=0.
  - On dmem_ready=1: stall=0 that cycle; at the edge, capture dmem_rdata into mem_read_data_out (reads only; writes keep it); load latched ALU result, wb control and destination; wb_valid=1; next state IDLE.
  - Minimum access latency: 2 cycles (IDLE + BUSY with immediate ready).
- dmem_ready in IDLE: ignored.
- stall=1 is a contract: upstream holds its inputs stable until stall=0.
- Branch and memory bits set together: both act; pc_src is independent of the FSM.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - cycle counter runs in BUSY and clears on entry.
  - When it reaches TIMEOUT_CYCLES with no ready: one-cycle bus_error output pulse, dmem_req dropped, state returns to IDLE.
  - Completing instruction at that edge: control_wb_out=0, wb_valid=1.
- Disabled: no counter and no bus_error port; BUSY waits indefinitely.

Decomposition:
- Shared package holds:
  - FSM state encoding;
  - control_mem bit indices (CM_BRANCH=2, CM_READ=1, CM_WRITE=0);
  - ZERO_BIT default;
  - DATA_W default.
- One natural sub-module: mem_timeout_counter (the watchdog), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset: RST_N=0 mid-BUSY -> dmem_req=0 immediately; all outputs 0; state IDLE after release.
- Load: control_mem_in=3'b010, ALU_result_in=0x100, ready after 3 BUSY cycles with rdata=0xDEADBEEF -> stall high 4 cycles; mem_read_data_out=0xDEADBEEF; wb_valid=1.
- Store: control_mem_in=3'b001, addr=0x204, data=0x12345678, immediate ready -> dmem_we=1, dmem_addr=0x204, dmem_wdata=0x12345678; 2-cycle latency; mem_read_data_out unchanged.
- Misaligned: read at 0x102 -> access_fault pulses 1 cycle; dmem_req never asserted; control_wb_out=0; stall=0.
- Branch: control_mem_in=3'b100, ALU_status_in[0]=1, branch_address_in=0x40 -> pc_src=1, branch_target=0x40; with zero flag=0 -> pc_src=0.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with dmem_ready held 0 -> bus_error pulse after 4 BUSY cycles; dmem_req drops; control_wb_out=0.
